// File: rtl/parity_rx_pkg.sv
// Package: parity_rx_pkg
// Shared types and helpers for the XOR-parity serial receiver.
//   prx_state_t  receiver FSM states
//   MAX_DATA_W   largest supported data width
//   cnt_width()  width of a counter that indexes 0..n-1 (minimum 1 bit)
package parity_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } prx_state_t;

    localparam int unsigned MAX_DATA_W = 16;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/parity_acc.sv
// Module: parity_acc
// Running XOR accumulator shared by the parity receiver and the transmitter-side
// parity generator.
// Ports:
//   clk     in   clock, rising edge
//   rst_n   in   synchronous active-low reset
//   clr     in   clear accumulator to 0 (has priority over en)
//   en      in   fold bit_in into the accumulator
//   bit_in  in   serial data bit
//   par     out  XOR of all bits folded in since the last clear
module parity_acc (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    output logic par
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par <= 1'b0;
        end else if (clr) begin
            par <= 1'b0;
        end else if (en) begin
            par <= par ^ bit_in;
        end
    end

endmodule

// File: rtl/parity_serial_rx.sv
// Module: parity_serial_rx
// Receiving end of the XOR-parity serial link. Deserialises a frame of
// start bit, DATA_W data bits (LSB first), parity bit and stop bit, one bit per
// bit_tick, checks parity and framing, and holds the word on a valid/ready
// output register.
// Optional feature: define PRX_ERR_COUNT_EN to add the saturating err_count port.
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   synchronous active-low reset
//   bit_tick    in   one-clk pulse at the centre of each bit period
//   rx_in       in   serial line, idle high, sampled only on bit_tick
//   data_out    out  received word
//   data_valid  out  word/flags valid, held until accepted
//   data_ready  in   consumer accepts when data_valid & data_ready
//   parity_err  out  parity mismatch on the held word
//   frame_err   out  stop bit sampled low on the held word
//   overrun     out  at least one frame dropped while this word was held
//   busy        out  FSM not in IDLE
//   err_count   out  (PRX_ERR_COUNT_EN only) errored + dropped frames, saturating
module parity_serial_rx
    import parity_rx_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ODD_PARITY = 0,
    parameter int unsigned CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_tick,
    input  logic              rx_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    input  logic              data_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
`ifdef PRX_ERR_COUNT_EN
    ,
    output logic [CNT_W-1:0]  err_count
`endif
);

    localparam int unsigned     BCW      = cnt_width(DATA_W);
    localparam logic [BCW-1:0]  LAST_BIT = BCW'(DATA_W - 1);
    localparam logic            ODD      = (ODD_PARITY != 0);

    generate
        if (DATA_W < 1 || DATA_W > MAX_DATA_W || CNT_W < 1) begin : g_bad_param
            $error("parity_serial_rx: unsupported DATA_W or CNT_W");
        end
    endgenerate

    prx_state_t        state;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shift_next;
    logic [BCW-1:0]    bit_cnt;
    logic              acc;
    logic              perr_q;
    logic              acc_clr;
    logic              acc_en;
    logic              done;
    logic              ferr;
    logic              load;
    logic              accept;

    assign acc_clr = bit_tick & (state == IDLE) & ~rx_in;
    assign acc_en  = bit_tick & (state == DATA);
    assign done    = bit_tick & (state == STOP);
    assign ferr    = ~rx_in;
    assign accept  = data_valid & data_ready;
    // A completing frame may replace the held word only if that word leaves this cycle.
    assign load    = done & (~data_valid | data_ready);

    // LSB-first frame: new bits enter at the MSB and walk down.
    generate
        if (DATA_W == 1) begin : g_shift_one
            assign shift_next = rx_in;
        end else begin : g_shift_many
            assign shift_next = {rx_in, shift_reg[DATA_W-1:1]};
        end
    endgenerate

    parity_acc u_parity_acc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (acc_clr),
        .en     (acc_en),
        .bit_in (rx_in),
        .par    (acc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            perr_q     <= 1'b0;
            busy       <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (bit_tick) begin
                unique case (state)
                    IDLE: begin
                        if (!rx_in) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                            busy    <= 1'b1;
                        end
                    end
                    DATA: begin
                        shift_reg <= shift_next;
                        if (bit_cnt == LAST_BIT) begin
                            state   <= PARITY;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + BCW'(1);
                        end
                    end
                    PARITY: begin
                        perr_q <= acc ^ rx_in ^ ODD;
                        state  <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end

            if (load) begin
                data_out   <= shift_reg;
                parity_err <= perr_q;
                frame_err  <= ferr;
                overrun    <= 1'b0;
                data_valid <= 1'b1;
            end else if (done) begin
                overrun <= 1'b1;
            end else if (accept) begin
                data_valid <= 1'b0;
                parity_err <= 1'b0;
                frame_err  <= 1'b0;
                overrun    <= 1'b0;
            end
        end
    end

`ifdef PRX_ERR_COUNT_EN
    logic err_inc;

    // Delivered-with-error and dropped are mutually exclusive for one frame.
    assign err_inc = done & (~load | perr_q | ferr);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (err_inc && (err_count != '1)) begin
            err_count <= err_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_parity_serial_rx.sv
module tb_parity_serial_rx;

    localparam int unsigned DW = 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          perr;
        logic          ferr;
        logic          ovr;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          bit_tick = 1'b0;
    logic          rx_in = 1'b1;
    logic          data_ready = 1'b0;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          parity_err;
    logic          frame_err;
    logic          overrun;
    logic          busy;
    logic [DW-1:0] o_data_out;
    logic          o_data_valid;
    logic          o_parity_err;
    logic          o_frame_err;
    logic          o_overrun;
    logic          o_busy;
    logic [DW-1:0] o_last_data = '0;
    logic          o_last_perr = 1'b0;
`ifdef PRX_ERR_COUNT_EN
    logic [1:0]    err_count;
    logic [1:0]    o_err_count;
    int            exp_cnt;
`endif

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    parity_serial_rx #(
        .DATA_W     (DW),
        .ODD_PARITY (0),
        .CNT_W      (2)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_tick   (bit_tick),
        .rx_in      (rx_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
`ifdef PRX_ERR_COUNT_EN
        ,
        .err_count  (err_count)
`endif
    );

    parity_serial_rx #(
        .DATA_W     (DW),
        .ODD_PARITY (1),
        .CNT_W      (2)
    ) u_dut_odd (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_tick   (bit_tick),
        .rx_in      (rx_in),
        .data_out   (o_data_out),
        .data_valid (o_data_valid),
        .data_ready (1'b1),
        .parity_err (o_parity_err),
        .frame_err  (o_frame_err),
        .overrun    (o_overrun),
        .busy       (o_busy)
`ifdef PRX_ERR_COUNT_EN
        ,
        .err_count  (o_err_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge, well clear of sampling.
    task automatic wait_clk();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_bit(input logic b);
        wait_clk();
        rx_in    = b;
        bit_tick = 1'b1;
        wait_clk();
        bit_tick = 1'b0;
        wait_clk();
        wait_clk();
    endtask

    task automatic send_head(input logic [DW-1:0] d, input logic pbit);
        drive_bit(1'b0);
        for (int i = 0; i < DW; i++) drive_bit(d[i]);
        drive_bit(pbit);
    endtask

    function automatic exp_t make_exp(input logic [DW-1:0] d, input logic pbit,
                                      input logic sbit, input logic ovr);
        exp_t e;
        e.data = d;
        e.perr = (^d) ^ pbit;
        e.ferr = ~sbit;
        e.ovr  = ovr;
        return e;
    endfunction

    task automatic send_frame(input logic [DW-1:0] d, input logic pbit, input logic sbit,
                              input logic ovr, input logic push);
        if (push) sb.push_back(make_exp(d, pbit, sbit, ovr));
        send_head(d, pbit);
        drive_bit(sbit);
        rx_in = 1'b1;
    endtask

    // Scoreboard: compare every word the consumer accepts.
    always @(negedge clk) begin
        if (rst_n && data_valid && data_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_word", 32'(data_out), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rx_data", 32'(data_out), 32'(e.data));
                check("rx_parity_err", 32'(parity_err), 32'(e.perr));
                check("rx_frame_err", 32'(frame_err), 32'(e.ferr));
                check("rx_overrun", 32'(overrun), 32'(e.ovr));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && o_data_valid) begin
            o_last_data <= o_data_out;
            o_last_perr <= o_parity_err;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] d;
        logic [DW-1:0] frames [4];

        // Reset state
        repeat (3) wait_clk();
        check("rst_data_out", 32'(data_out), 32'h0);
        check("rst_data_valid", 32'(data_valid), 32'h0);
        check("rst_parity_err", 32'(parity_err), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst_n      = 1'b1;
        data_ready = 1'b1;
        wait_clk();

        // Test 1: 0xA5 good even parity, with latency check on the stop tick
        d = 8'hA5;
        sb.push_back(make_exp(d, 1'b0, 1'b1, 1'b0));
        send_head(d, 1'b0);
        check("t1_busy_mid", 32'(busy), 32'h1);
        wait_clk();
        rx_in    = 1'b1;
        bit_tick = 1'b1;
        check("t1_valid_before", 32'(data_valid), 32'h0);
        wait_clk();
        bit_tick = 1'b0;
        check("t1_valid_after", 32'(data_valid), 32'h1);
        check("t1_busy_after", 32'(busy), 32'h0);
        repeat (3) wait_clk();
        check("t1_odd_data", 32'(o_last_data), 32'hA5);
        check("t1_odd_perr", 32'(o_last_perr), 32'h1);

        // Test 2: 0xA5 with parity bit 1
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b1);
        check("t2_odd_data", 32'(o_last_data), 32'hA5);
        check("t2_odd_perr", 32'(o_last_perr), 32'h0);

        // Test 3: 0x3C with stop bit low
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);

        // Test 4: consumer stalled, second frame dropped
        data_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b1, 1'b1, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t4_valid_held", 32'(data_valid), 32'h1);
        check("t4_data_held", 32'(data_out), 32'h11);
        check("t4_overrun", 32'(overrun), 32'h1);
        data_ready = 1'b1;
        wait_clk();
        data_ready = 1'b0;
        check("t4_valid_clear", 32'(data_valid), 32'h0);
        check("t4_overrun_clear", 32'(overrun), 32'h0);
        check("t4_data_kept", 32'(data_out), 32'h11);
        data_ready = 1'b1;

        // Test 5: reset during the 4th data bit abandons the frame
        d = 8'hC3;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(d[i]);
        wait_clk();
        rx_in    = d[3];
        bit_tick = 1'b1;
        rst_n    = 1'b0;
        wait_clk();
        bit_tick = 1'b0;
        rst_n    = 1'b1;
        rx_in    = 1'b1;
        check("t5_busy", 32'(busy), 32'h0);
        check("t5_valid", 32'(data_valid), 32'h0);
        repeat (3) wait_clk();
        check("t5_no_valid", 32'(data_valid), 32'h0);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b1);

`ifdef PRX_ERR_COUNT_EN
        // Test 6: saturating error counter
        rst_n = 1'b0;
        wait_clk();
        rst_n = 1'b1;
        check("t6_cnt_rst", 32'(err_count), 32'h0);
        exp_cnt   = 0;
        frames[0] = 8'h01;
        frames[1] = 8'h7E;
        frames[2] = 8'h80;
        frames[3] = 8'hF0;
        for (int i = 0; i < 4; i++) begin
            send_frame(frames[i], ~(^frames[i]), 1'b1, 1'b0, 1'b1);
            exp_cnt = (exp_cnt == 3) ? 3 : exp_cnt + 1;
            check("t6_err_count", 32'(err_count), 32'(exp_cnt));
        end
`endif

        repeat (5) wait_clk();
        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
